// File: rtl/dtree_pkg.sv
// Shared types and defaults for the decision-tree feature sequencer.
// The lane helper slices one feature byte out of a default-sized feature vector.
package dtree_pkg;

    localparam int N_FEAT_DEF = 4;
    localparam int FEAT_W_DEF = 8;
    localparam int CLS_W_DEF  = 2;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [FEAT_W_DEF-1:0] feat_lane(
        input logic [N_FEAT_DEF*FEAT_W_DEF-1:0] vec,
        input int unsigned                      lane
    );
        return vec[lane*FEAT_W_DEF +: FEAT_W_DEF];
    endfunction

endpackage

// File: rtl/dtree_settle_timer.sv
// Loadable down-counter; o_done flags the enabled cycle in which the count is zero.
// A load takes priority over counting.
module dtree_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/dtree_feature_sequencer.sv
// Streams feature bytes into a parallel vector, lets the external tree settle,
// then samples its class and offers it on a valid/ready result port.
module dtree_feature_sequencer
    import dtree_pkg::*;
#(
    parameter int N_FEAT     = N_FEAT_DEF,
    parameter int FEAT_W     = FEAT_W_DEF,
    parameter int CLS_W      = CLS_W_DEF,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_vec,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     m_err
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int VEC_W = N_FEAT * FEAT_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;
    logic [VEC_W-1:0]   r_shadow;
    logic [VEC_W-1:0]   w_shadow_next;
    logic               w_beat;
    logic               w_xfer;
    logic               w_last_lane;
    logic               w_settle_done;

    // s_ready comes straight from the state register, never from s_valid.
    assign s_ready     = (r_state == LOAD);
    assign w_beat      = s_valid && s_ready;
    assign w_xfer      = m_valid && m_ready;
    assign w_last_lane = (r_idx == IDX_W'(N_FEAT - 1));

    dtree_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_beat && s_last),
        .i_load_val (CNT_W'(SETTLE_CYC - 1)),
        .i_en       (r_state == SETTLE),
        .o_done     (w_settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    if (w_beat && s_last) w_state_next = SETTLE;
            SETTLE:  if (w_settle_done)    w_state_next = HOLD;
            HOLD:    if (w_xfer)           w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    // After a long-frame overflow (r_err set in LOAD) extra bytes are dropped.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int i = 0; i < N_FEAT; i++) begin
            if ((r_idx == IDX_W'(i)) && !r_err) begin
                w_shadow_next[i*FEAT_W +: FEAT_W] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_shadow <= '0;
            feat_vec <= '0;
            m_valid  <= 1'b0;
            m_class  <= '0;
            m_err    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_beat) begin
                        if (!w_last_lane) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                        if (s_last) begin
                            // Shadow is cleared here so a short next frame reads zeros in unsent lanes.
                            feat_vec <= w_shadow_next;
                            r_shadow <= '0;
                            if (!w_last_lane) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_shadow <= w_shadow_next;
                            if (w_last_lane) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        m_class <= cls_in;
                        m_err   <= r_err;
                        m_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        m_valid <= 1'b0;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dtree_feature_sequencer.md
Name: dtree_feature_sequencer

Overview:
Sequential front end for the combinational printed decision-tree classifiers (4 × 8-bit features in, 2-bit class out).
- Accepts feature bytes one per beat on a valid/ready stream and assembles them into the parallel feature vector.
- Holds the vector stable on the classifier inputs for a settle window, then samples the class.
- Returns the class on an output valid/ready handshake.
- Sits between the sensor/ADC byte stream and the tree, so a combinational tree can run in a streaming system.

Parameters:
- N_FEAT, 4, number of features per sample (X0..X{N_FEAT-1}).
- FEAT_W, 8, bits per feature.
- CLS_W, 2, class output width.
- SETTLE_CYC, 2, cycles the vector is held before the class is sampled (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  feature byte valid.
- s_ready  out  1  sequencer can accept a byte.
- s_data  in  FEAT_W  feature byte; arrival order X0 first.
- s_last  in  1  marks the final byte of a sample.
- feat_vec  out  N_FEAT*FEAT_W  registered vector to the classifier; X0 in the LSBs.
- cls_in  in  CLS_W  class from the combinational classifier.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_class  out  CLS_W  captured class.
- m_err  out  1  sample framing error, qualified by m_valid.

Behaviour:
- Reset is synchronous and active-high. On the clk edge with rst=1:
  - state=LOAD, idx=0, err=0.
  - feat_vec=0, m_valid=0, m_class=0, m_err=0.
  - s_ready=1 from the first cycle after reset.
- A beat transfers when s_valid && s_ready. A result transfers when m_valid && m_ready.
- State LOAD (s_ready=1):
  - Each beat writes s_data into lane idx of a shadow register, then idx++.
  - When s_last=1 on a beat: copy the shadow into feat_vec in the same edge (feat_vec updates only here), load settle counter=SETTLE_CYC-1, go to SETTLE.
  - If s_last arrives with idx≠N_FEAT-1 (short frame): err=1 and unreceived lanes are zero. The tree is still evaluated.
  - If idx reaches N_FEAT-1 with s_last=0 (long frame): err=1. Further beats are accepted and discarded, and idx stays saturated, until s_last.
- State SETTLE (s_ready=0):
  - The counter decrements each cycle.
  - At counter==0: m_class<=cls_in, m_err<=err, m_valid<=1, go to HOLD.
  - Class is sampled SETTLE_CYC cycles after the edge that loaded feat_vec. With SETTLE_CYC=1, it is sampled on the next edge.
- State HOLD (s_ready=0):
  - m_valid, m_class and m_err are held stable until transfer.
  - On transfer: m_valid<=0, idx<=0, err<=0, go to LOAD. s_ready=1 on the next cycle.
  - feat_vec keeps its value until the next sample's final beat.
- Latency: final input beat to m_valid high is SETTLE_CYC+1 edges. Best-case throughput is one sample per N_FEAT+SETTLE_CYC+1 cycles.
- No input is accepted in SETTLE or HOLD; s_data and s_last are ignored there.
- rst asserted mid-frame or mid-result discards any partial sample and any pending result. No spurious m_valid follows.
- s_ready is a registered function of state; it does not depend combinationally on s_valid.
- Width rules:
  - idx is clog2(N_FEAT) bits with saturating increment.
  - The settle counter is clog2(SETTLE_CYC+1) bits.

Decomposition:
- Shared package dtree_pkg holds:
  - localparams for FEAT_W and CLS_W defaults.
  - the state enum {LOAD, SETTLE, HOLD}.
  - a function that slices feature lane i from feat_vec.
- One sub-module is natural: dtree_settle_timer, a loadable down-counter with a done pulse, used by the SETTLE state.
- The classifier itself stays external and is connected by the integration top.

Test Plan:
- Basic sample:
  - Stimulus: after reset, bytes 0x10, 0x20, 0x30, 0x40 with s_last on the 4th; stub classifier drives cls_in=2.
  - Required: feat_vec=0x40302010, m_valid rises 3 cycles after the last beat (SETTLE_CYC=2), m_class=2, m_err=0.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles.
  - Required: m_valid and m_class stay stable, s_ready=0 throughout; after m_ready=1, s_ready=1 on the next cycle.
- Short frame:
  - Stimulus: bytes 0xAA, 0xBB with s_last on the 2nd.
  - Required: feat_vec=0x0000BBAA, m_err=1, class still returned.
- Long frame:
  - Stimulus: 6 bytes, s_last on the 6th.
  - Required: lanes X0..X3 hold the first four bytes, bytes 5 and 6 are discarded, m_err=1.
- Reset mid-frame:
  - Stimulus: rst pulse after 2 of 4 bytes, then a clean frame 1, 2, 3, 4.
  - Required: feat_vec=0x04030201, m_err=0, exactly one m_valid pulse-train.
- Back-to-back samples:
  - Stimulus: 3 frames with m_ready tied high and classifier stub cls_in = X0[7:6].
  - Required: each m_class matches its own frame.
  - Required: feat_vec never changes during SETTLE or HOLD.
